gru_seq_controller: RTL
=======================

Name: gru_seq_controller

Overview:
- Sequencer inside GRU_Serial_Top between the board-level serial/button/LED pins and the GRU datapath core.
- Deserialises one input sequence of SEQUENCE_LENGTH x INPUT_FEATURES IEEE-754 words into a local buffer.
- On start, clears the core hidden state, steps the core once per timestep via a start/done handshake, then serialises the 32-bit prediction MSB-first.
- Drives led_state, led_ready, led_loading and led_done.

Parameters:
- DATA_WIDTH, 32, word width.
- INPUT_FEATURES, 3, words per timestep.
- SEQUENCE_LENGTH, 3, timesteps per sequence.
- TX_HALF, 4, clk cycles per half-period of serial_clk_out.
- DONE_HOLD, 16, cycles spent in DONE before returning to IDLE.

Ports:
- clk  in  1  system clock.
- rstn  in  1  synchronous active-low reset.
- btn_start  in  1  asynchronous start button, level.
- serial_load_en  in  1  asynchronous load window.
- serial_clk_in  in  1  asynchronous serial bit strobe; rising edge = bit valid.
- serial_data_in  in  1  asynchronous serial data, MSB first.
- core_x  out  INPUT_FEATURES*DATA_WIDTH  current timestep vector; feature 0 in the LSBs.
- core_h_clear  out  1  one-cycle pulse that zeroes the core hidden state.
- core_start  out  1  one-cycle pulse that starts one timestep.
- core_last  out  1  high with core_start on the final timestep.
- core_done  in  1  one-cycle pulse: step finished.
- core_result  in  DATA_WIDTH  prediction; valid on core_done while core_last was set.
- serial_data_out  out  1  output bit.
- serial_clk_out  out  1  output bit clock.
- serial_valid  out  1  high for the whole transmission.
- led_state  out  4  FSM encoding.
- led_ready  out  1  high in READY.
- led_loading  out  1  high in LOADING.
- led_done  out  1  sticky completion flag.

Behaviour:
- Reset: clk and rstn only. All asynchronous inputs pass through 2-FF synchronisers. All outputs reset to 0, FSM to IDLE, word and bit counters to 0, buffer contents don't-care.
- States and led_state codes: IDLE=1, LOADING=2, READY=3, CLEAR=4, STEP=5, WAIT=6, TX=7, DONE=8. Codes 0 and 9-15 are unused; an illegal state recovers to IDLE.
- IDLE:
  - Synced serial_load_en high -> LOADING, clear word count, clear led_done.
  - btn_start is ignored.
- LOADING:
  - Each synced rising edge of serial_clk_in shifts the synced serial_data_in into a 32-bit shift register, MSB first.
  - On the 32nd bit, the word is written to buffer[word_cnt] and word_cnt increments.
  - Words beyond N = SEQUENCE_LENGTH*INPUT_FEATURES are discarded.
  - When load_en falls: word_cnt == N -> READY; otherwise -> IDLE, with no error flag. A partial word is discarded.
- READY:
  - A synced rising edge of btn_start -> CLEAR. A held button does not retrigger.
  - load_en high -> LOADING, restarting the load (reload is allowed).
- CLEAR:
  - Pulse core_h_clear for 1 cycle, set t=0 -> STEP.
- STEP:
  - core_x = buffer words t*F .. t*F+F-1.
  - Pulse core_start for 1 cycle, with core_last = (t == SEQUENCE_LENGTH-1) -> WAIT.
  - core_x holds stable until core_done.
- WAIT:
  - core_done with t < last: t++ -> STEP. The next core_start follows core_done by exactly 2 cycles.
  - core_done with t == last: latch core_result -> TX.
  - No timeout.
- TX:
  - serial_valid rises on entry, and serial_data_out = bit 31 on the same cycle.
  - Each bit: serial_clk_out low for TX_HALF cycles, then high for TX_HALF cycles. Data changes only on the high-to-low transition.
  - After bit 0's high half: serial_clk_out=0, serial_valid=0, led_done=1 -> DONE.
- DONE:
  - Count DONE_HOLD cycles -> IDLE.
  - led_done stays 1 until the next LOADING entry.
- btn_start or load_en activity in CLEAR, STEP, WAIT, TX or DONE is ignored.
- rstn low in any state, including mid-TX, forces reset values on the next edge. serial_valid drops immediately.

Test Plan:
- Reset and idle: hold rstn low 20 cycles, release -> led_state=1. All other outputs 0 for 100 cycles with btn_start pulsed.
- Nominal run:
  - Stimulus: load 9 words 0x3F800000..0x41100000, then btn_start 5 cycles. Model core returns done 10 cycles after start, result 0x3E4CCCCD.
  - Response: led_state 2 then 3; one core_h_clear; exactly 3 core_start pulses.
  - core_x on t=1 = {0x40C00000,0x40A00000,0x40800000}; core_last only on the third pulse.
  - Received serial word = 0x3E4CCCCD; led_done=1; state returns to 1 after 16 cycles.
- Short load: load_en falls after 8 words -> led_state=1; btn_start produces no core_start.
- Over-long load: 10 words sent -> READY; buffer holds the first 9 words, the 10th is dropped.
- Back-to-back sequences:
  - Second load clears led_done at LOADING entry.
  - Second result 0xBF000000 is received correctly.
  - Held btn_start (200 cycles) gives exactly one run.
- Mid-TX reset: assert rstn after 10 bits have been sent -> serial_valid=0 and led_state=1 the next cycle. A new load and run then completes normally.

Source files
------------

// File: rtl/gru_seq_controller.sv
// Sequencer between board serial/button/LED pins and the GRU datapath core.
// It loads SEQUENCE_LENGTH x INPUT_FEATURES words serially, steps the core once per timestep,
// and shifts the DATA_WIDTH-bit prediction out MSB-first.
// Ports: clk/rstn (sync, active-low); btn_start, serial_load_en, serial_clk_in and serial_data_in
//   are async and each passes through a 2-FF synchroniser.
//   core_x/core_h_clear/core_start/core_last/core_done/core_result form the core handshake.
//   serial_data_out/serial_clk_out/serial_valid carry the result; led_* are status outputs.
module gru_seq_controller #(
  parameter int DATA_WIDTH      = 32,
  parameter int INPUT_FEATURES  = 3,
  parameter int SEQUENCE_LENGTH = 3,
  parameter int TX_HALF         = 4,
  parameter int DONE_HOLD       = 16
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 btn_start,
  input  logic                                 serial_load_en,
  input  logic                                 serial_clk_in,
  input  logic                                 serial_data_in,
  output logic [INPUT_FEATURES*DATA_WIDTH-1:0] core_x,
  output logic                                 core_h_clear,
  output logic                                 core_start,
  output logic                                 core_last,
  input  logic                                 core_done,
  input  logic [DATA_WIDTH-1:0]                core_result,
  output logic                                 serial_data_out,
  output logic                                 serial_clk_out,
  output logic                                 serial_valid,
  output logic [3:0]                           led_state,
  output logic                                 led_ready,
  output logic                                 led_loading,
  output logic                                 led_done
);

  localparam int N   = SEQUENCE_LENGTH * INPUT_FEATURES;
  localparam int VW  = INPUT_FEATURES * DATA_WIDTH;
  localparam int CW  = $clog2(N + 1);
  localparam int TW  = (SEQUENCE_LENGTH > 1) ? $clog2(SEQUENCE_LENGTH) : 1;
  localparam int BW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int HW  = (TX_HALF > 1) ? $clog2(TX_HALF) : 1;
  localparam int DCW = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;

  localparam logic [CW-1:0]  N_WORDS   = CW'(N);
  localparam logic [TW-1:0]  T_LAST    = TW'(SEQUENCE_LENGTH - 1);
  localparam logic [BW-1:0]  BIT_LAST  = BW'(DATA_WIDTH - 1);
  localparam logic [HW-1:0]  HALF_LAST = HW'(TX_HALF - 1);
  localparam logic [DCW-1:0] HOLD_LAST = DCW'(DONE_HOLD - 1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd1,
    S_LOADING = 4'd2,
    S_READY   = 4'd3,
    S_CLEAR   = 4'd4,
    S_STEP    = 4'd5,
    S_WAIT    = 4'd6,
    S_TX      = 4'd7,
    S_DONE    = 4'd8
  } state_t;

  state_t state_q, state_d;

  // Synchronisers: bit [1] is the synced value, bit [2] its previous cycle for edge detection.
  logic [2:0] btn_sr, len_sr, sclk_sr;
  logic [1:0] sdat_sr;
  logic       btn_rise, load_en, sclk_rise, sdat;

  logic [CW-1:0]         word_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-2:0] shreg;
  logic [N*DATA_WIDTH-1:0] buf_flat;
  logic [TW-1:0]         t_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic [BW-1:0]         bit_idx;
  logic [HW-1:0]         tx_cnt;
  logic [DCW-1:0]        done_cnt;
  logic                  word_done;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      btn_sr  <= '0;
      len_sr  <= '0;
      sclk_sr <= '0;
      sdat_sr <= '0;
    end else begin
      btn_sr  <= {btn_sr[1:0], btn_start};
      len_sr  <= {len_sr[1:0], serial_load_en};
      sclk_sr <= {sclk_sr[1:0], serial_clk_in};
      sdat_sr <= {sdat_sr[0], serial_data_in};
    end
  end

  assign btn_rise  = btn_sr[1] & ~btn_sr[2];
  assign load_en   = len_sr[1];
  assign sclk_rise = sclk_sr[1] & ~sclk_sr[2];
  // Data and strobe share the same synchroniser depth, so they stay aligned.
  assign sdat      = sdat_sr[1];
  assign word_done = (state_q == S_LOADING) && sclk_rise && (bit_cnt == BIT_LAST);

  always_ff @(posedge clk) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (load_en) state_d = S_LOADING;
      S_LOADING: if (!load_en) state_d = (word_cnt == N_WORDS) ? S_READY : S_IDLE;
      S_READY: begin
        if (load_en)       state_d = S_LOADING;
        else if (btn_rise) state_d = S_CLEAR;
      end
      S_CLEAR:   state_d = S_STEP;
      S_STEP:    state_d = S_WAIT;
      S_WAIT:    if (core_done) state_d = (t_q == T_LAST) ? S_TX : S_STEP;
      S_TX:      if (tx_cnt == HALF_LAST && serial_clk_out && bit_idx == '0) state_d = S_DONE;
      S_DONE:    if (done_cnt == HOLD_LAST) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Sequence buffer; word k lives at bits [k*DATA_WIDTH +: DATA_WIDTH]. Extra words find no slot.
  always_ff @(posedge clk) begin
    if (word_done) begin
      for (int w = 0; w < N; w++) begin
        if (word_cnt == CW'(w)) buf_flat[w*DATA_WIDTH +: DATA_WIDTH] <= {shreg, sdat};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      word_cnt        <= '0;
      bit_cnt         <= '0;
      shreg           <= '0;
      t_q             <= '0;
      core_x          <= '0;
      core_h_clear    <= 1'b0;
      core_start      <= 1'b0;
      core_last       <= 1'b0;
      result_q        <= '0;
      serial_data_out <= 1'b0;
      serial_clk_out  <= 1'b0;
      serial_valid    <= 1'b0;
      bit_idx         <= '0;
      tx_cnt          <= '0;
      done_cnt        <= '0;
      led_done        <= 1'b0;
    end else begin
      // Core pulses are registered, which puts core_start two cycles after core_done.
      core_h_clear <= (state_q == S_CLEAR);
      core_start   <= (state_q == S_STEP);
      core_last    <= (state_q == S_STEP) && (t_q == T_LAST);

      if (state_d == S_LOADING && state_q != S_LOADING) begin
        word_cnt <= '0;
        bit_cnt  <= '0;
        led_done <= 1'b0;
      end

      case (state_q)
        S_LOADING: begin
          if (sclk_rise) begin
            shreg   <= {shreg[DATA_WIDTH-3:0], sdat};
            bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST && word_cnt != N_WORDS) word_cnt <= word_cnt + 1'b1;
          end
        end
        S_CLEAR: t_q <= '0;
        S_STEP: begin
          for (int s = 0; s < SEQUENCE_LENGTH; s++) begin
            if (t_q == TW'(s)) core_x <= buf_flat[s*VW +: VW];
          end
        end
        S_WAIT: begin
          if (core_done) begin
            if (t_q != T_LAST) begin
              t_q <= t_q + 1'b1;
            end else begin
              result_q        <= core_result;
              serial_valid    <= 1'b1;
              serial_data_out <= core_result[DATA_WIDTH-1];
              serial_clk_out  <= 1'b0;
              tx_cnt          <= '0;
              bit_idx         <= BIT_LAST;
            end
          end
        end
        S_TX: begin
          if (tx_cnt == HALF_LAST) begin
            tx_cnt <= '0;
            if (!serial_clk_out) begin
              serial_clk_out <= 1'b1;
            end else begin
              // Data only moves on the high-to-low transition of the bit clock.
              serial_clk_out <= 1'b0;
              if (bit_idx == '0) begin
                serial_valid <= 1'b0;
                led_done     <= 1'b1;
                done_cnt     <= '0;
              end else begin
                bit_idx         <= bit_idx - 1'b1;
                serial_data_out <= result_q[bit_idx - 1'b1];
              end
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        S_DONE: done_cnt <= done_cnt + 1'b1;
        default: begin
          serial_valid   <= 1'b0;
          serial_clk_out <= 1'b0;
        end
      endcase
    end
  end

  assign led_state   = state_q;
  assign led_ready   = (state_q == S_READY);
  assign led_loading = (state_q == S_LOADING);

endmodule
